// File: rtl/alu_cp0_control.sv
// alu_cp0_control: decode/execute core of the single-cycle MIPS CPU.
//   - main control decode of the current instruction
//   - 4-bit-op ALU with operand muxing (shamt / immediate / register)
//   - coprocessor 0: Status (12), Cause (13), EPC (14), interrupt entry,
//     mfc0, mtc0 and eret
// Everything is combinational except the CP0 state and the exp_src
// edge-detect history.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset of CP0 state
//   inst, pc        current instruction and its address
//   rs_data/rt_data register-file read data
//   exp_src[2:0]    interrupt request lines, bit 0 highest priority
//   ctrl[17:0]      {RegDst, RegWrite, ALUSrc, ZeroExtend, IsShamt, MemRead,
//                    MemWrite, MemtoReg, Branch, BneOrBeq, Jump, IsJAL, IsJR,
//                    IsSyscall, IsCOP0, ReadRs, ReadRt, IsEret}
//   alu_op, alu_result, equal, branch_taken   ALU outputs
//   has_exp         interrupt taken this cycle
//   exp_block       interrupts globally disabled (~Status.IE)
//   ex_reg_write    mfc0 writes the register file
//   cp0_dout        mfc0 read data
//   cp0_pcout       handler vector when has_exp, else EPC (eret target)
module alu_cp0_control #(
  parameter logic [31:0] HANDLER_VEC = 32'h0000_0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [2:0]  exp_src,
  output logic [17:0] ctrl,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_result,
  output logic        equal,
  output logic        branch_taken,
  output logic        has_exp,
  output logic        exp_block,
  output logic        ex_reg_write,
  output logic [31:0] cp0_dout,
  output logic [31:0] cp0_pcout
);

  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRA  = 4'd1;
  localparam logic [3:0] ALU_SRL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd5;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_XOR  = 4'd9;
  localparam logic [3:0] ALU_NOR  = 4'd10;
  localparam logic [3:0] ALU_SLT  = 4'd11;
  localparam logic [3:0] ALU_SLTU = 4'd12;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  logic [5:0] opcode, funct;
  logic [4:0] rs_f, rd_f;

  assign opcode = inst[31:26];
  assign rs_f   = inst[25:21];
  assign rd_f   = inst[15:11];
  assign funct  = inst[5:0];

  // The rt field is not needed here: the register file already supplies rt_data.
  logic unused_rt_field;
  assign unused_rt_field = ^inst[20:16];

  // ---------------------------------------------------------------- decode
  logic reg_dst, reg_write, alu_src, zero_ext, is_shamt, mem_read, mem_write;
  logic mem_to_reg, branch, bne_or_beq, jump, is_jal, is_jr, is_syscall;
  logic is_cop0, read_rs, read_rt, is_eret, is_mfc0, is_mtc0;

  always_comb begin
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    zero_ext   = 1'b0;
    is_shamt   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    bne_or_beq = 1'b0;
    jump       = 1'b0;
    is_jal     = 1'b0;
    is_jr      = 1'b0;
    is_syscall = 1'b0;
    is_cop0    = 1'b0;
    read_rs    = 1'b0;
    read_rt    = 1'b0;
    is_eret    = 1'b0;
    is_mfc0    = 1'b0;
    is_mtc0    = 1'b0;
    alu_op     = ALU_SLL;
    case (opcode)
      6'h00: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        read_rs   = 1'b1;
        read_rt   = 1'b1;
        case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2A: alu_op = ALU_SLT;
          6'h2B: alu_op = ALU_SLTU;
          6'h00: begin alu_op = ALU_SLL; is_shamt = 1'b1; read_rs = 1'b0; end
          6'h02: begin alu_op = ALU_SRL; is_shamt = 1'b1; read_rs = 1'b0; end
          6'h03: begin alu_op = ALU_SRA; is_shamt = 1'b1; read_rs = 1'b0; end
          6'h08: begin is_jr = 1'b1; reg_write = 1'b0; end
          6'h0C: begin is_syscall = 1'b1; reg_write = 1'b0; end
          default: begin
            // unknown funct: no control asserted at all
            reg_dst   = 1'b0;
            reg_write = 1'b0;
            read_rs   = 1'b0;
            read_rt   = 1'b0;
          end
        endcase
      end
      6'h08, 6'h09: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; alu_op = ALU_ADD; end
      6'h0A: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; alu_op = ALU_SLT; end
      6'h0B: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; alu_op = ALU_SLTU; end
      6'h0C: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; end
      6'h0D: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR; end
      6'h0E: begin alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1; zero_ext = 1'b1; alu_op = ALU_XOR; end
      6'h23: begin
        alu_src = 1'b1; reg_write = 1'b1; read_rs = 1'b1;
        mem_read = 1'b1; mem_to_reg = 1'b1; alu_op = ALU_ADD;
      end
      6'h2B: begin
        alu_src = 1'b1; read_rs = 1'b1; read_rt = 1'b1;
        mem_write = 1'b1; alu_op = ALU_ADD;
      end
      6'h04, 6'h05: begin
        branch = 1'b1; read_rs = 1'b1; read_rt = 1'b1; alu_op = ALU_SUB;
        bne_or_beq = opcode[0];
      end
      6'h02: jump = 1'b1;
      6'h03: begin jump = 1'b1; is_jal = 1'b1; reg_write = 1'b1; end
      6'h10: begin
        case (rs_f)
          5'h00: begin is_cop0 = 1'b1; is_mfc0 = 1'b1; end
          5'h04: begin is_cop0 = 1'b1; is_mtc0 = 1'b1; read_rt = 1'b1; end
          5'h10: begin
            if (funct == 6'h18) begin
              is_cop0 = 1'b1;
              is_eret = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctrl = {reg_dst, reg_write, alu_src, zero_ext, is_shamt, mem_read,
                 mem_write, mem_to_reg, branch, bne_or_beq, jump, is_jal,
                 is_jr, is_syscall, is_cop0, read_rs, read_rt, is_eret};

  // ------------------------------------------------------------------- ALU
  logic [31:0] imm, x, y;

  assign imm = zero_ext ? {16'h0000, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
  // Shifts take the value from rt and the amount from the shamt field.
  assign x   = is_shamt ? rt_data : rs_data;
  assign y   = is_shamt ? {27'd0, inst[10:6]} : (alu_src ? imm : rt_data);

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_SLL:  alu_result = x << y[4:0];
      ALU_SRA:  alu_result = $signed(x) >>> y[4:0];
      ALU_SRL:  alu_result = x >> y[4:0];
      ALU_ADD:  alu_result = x + y;
      ALU_SUB:  alu_result = x - y;
      ALU_AND:  alu_result = x & y;
      ALU_OR:   alu_result = x | y;
      ALU_XOR:  alu_result = x ^ y;
      ALU_NOR:  alu_result = ~(x | y);
      ALU_SLT:  alu_result = {31'd0, $signed(x) < $signed(y)};
      ALU_SLTU: alu_result = {31'd0, x < y};
      default:  alu_result = 32'd0;
    endcase
  end

  assign equal        = (x == y);
  assign branch_taken = branch & (bne_or_beq ? ~equal : equal);

  // ------------------------------------------------------------------- CP0
  logic        ie_q, ie_d;
  logic [2:0]  mask_q, mask_d;
  logic [2:0]  pend_q, pend_d;
  logic [2:0]  prev_q;
  logic [31:0] epc_q, epc_d;
  logic [2:0]  eligible, clear_1h, rise;

  assign eligible = pend_q & ~mask_q;
  // two's-complement trick isolates the lowest set bit (highest priority)
  assign clear_1h = eligible & (~eligible + 3'd1);
  assign rise     = exp_src & ~prev_q;

  assign has_exp      = ie_q & (|eligible) & ~is_eret & ~reset;
  assign exp_block    = ~ie_q;
  assign ex_reg_write = is_mfc0;
  assign cp0_pcout    = has_exp ? HANDLER_VEC : epc_q;

  always_comb begin
    cp0_dout = 32'd0;
    case (rd_f)
      CP0_STATUS: cp0_dout = {28'd0, mask_q, ie_q};
      CP0_CAUSE:  cp0_dout = {29'd0, pend_q};
      CP0_EPC:    cp0_dout = epc_q;
      default:    cp0_dout = 32'd0;
    endcase
  end

  always_comb begin
    ie_d   = ie_q;
    mask_d = mask_q;
    pend_d = pend_q;
    epc_d  = epc_q;
    if (has_exp) begin
      // interrupt entry wins over any mtc0 issued in the same cycle
      epc_d  = pc;
      ie_d   = 1'b0;
      pend_d = pend_q & ~clear_1h;
    end else begin
      if (is_eret) begin
        ie_d = 1'b1;
      end
      if (is_mtc0) begin
        case (rd_f)
          CP0_STATUS: begin ie_d = rt_data[0]; mask_d = rt_data[3:1]; end
          CP0_CAUSE:  pend_d = rt_data[2:0];
          CP0_EPC:    epc_d = rt_data;
          default: ;
        endcase
      end
    end
    // a fresh request edge survives a same-cycle clear or overwrite
    pend_d = pend_d | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      mask_q <= 3'd0;
      pend_q <= 3'd0;
      epc_q  <= 32'd0;
      prev_q <= 3'd0;
    end else begin
      ie_q   <= ie_d;
      mask_q <= mask_d;
      pend_q <= pend_d;
      epc_q  <= epc_d;
      prev_q <= exp_src;
    end
  end

endmodule

// File: tb/tb_alu_cp0_control.sv
// Bench for alu_cp0_control: directed steps followed by randomized
// instruction streams, checked against a behavioural model.
module tb_alu_cp0_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst, pc, rs_data, rt_data;
  logic [2:0]  exp_src;
  logic [17:0] ctrl;
  logic [3:0]  alu_op;
  logic [31:0] alu_result, cp0_dout, cp0_pcout;
  logic        equal, branch_taken, has_exp, exp_block, ex_reg_write;

  always #5 clk = ~clk;

  alu_cp0_control dut (
    .clk(clk), .reset(reset), .inst(inst), .pc(pc), .rs_data(rs_data),
    .rt_data(rt_data), .exp_src(exp_src), .ctrl(ctrl), .alu_op(alu_op),
    .alu_result(alu_result), .equal(equal), .branch_taken(branch_taken),
    .has_exp(has_exp), .exp_block(exp_block), .ex_reg_write(ex_reg_write),
    .cp0_dout(cp0_dout), .cp0_pcout(cp0_pcout)
  );

  int checks = 0;
  int errors = 0;

  // control-word flags, named by meaning
  localparam logic [17:0] F_REGDST = 18'd1 << 17, F_REGWR = 18'd1 << 16;
  localparam logic [17:0] F_ALUSRC = 18'd1 << 15, F_ZEXT  = 18'd1 << 14;
  localparam logic [17:0] F_SHAMT  = 18'd1 << 13, F_MRD   = 18'd1 << 12;
  localparam logic [17:0] F_MWR    = 18'd1 << 11, F_M2R   = 18'd1 << 10;
  localparam logic [17:0] F_BR     = 18'd1 << 9,  F_BNE   = 18'd1 << 8;
  localparam logic [17:0] F_JUMP   = 18'd1 << 7,  F_JAL   = 18'd1 << 6;
  localparam logic [17:0] F_JR     = 18'd1 << 5,  F_SYS   = 18'd1 << 4;
  localparam logic [17:0] F_COP0   = 18'd1 << 3,  F_RS    = 18'd1 << 2;
  localparam logic [17:0] F_RT     = 18'd1 << 1,  F_ERET  = 18'd1;

  // behavioural CP0 state
  logic        m_ie, m_has;
  logic [2:0]  m_mask, m_pend, m_prev;
  logic [31:0] m_epc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_inst(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction
  function automatic logic [31:0] mtc0(input logic [4:0] rd);
    return {6'h10, 5'h04, 5'd0, rd, 11'd0};
  endfunction
  function automatic logic [31:0] mfc0(input logic [4:0] rd);
    return {6'h10, 5'h00, 5'd0, rd, 11'd0};
  endfunction
  function automatic logic [31:0] eret_i();
    return {6'h10, 5'h10, 15'd0, 6'h18};
  endfunction

  function automatic logic is_eret(input logic [31:0] i);
    return i[31:26] == 6'h10 && i[25:21] == 5'h10 && i[5:0] == 6'h18;
  endfunction
  function automatic logic is_mfc0(input logic [31:0] i);
    return i[31:26] == 6'h10 && i[25:21] == 5'h00;
  endfunction
  function automatic logic is_mtc0(input logic [31:0] i);
    return i[31:26] == 6'h10 && i[25:21] == 5'h04;
  endfunction

  // Expected control word and arithmetic per instruction mnemonic.
  // ak=1 means the ALU outputs are meaningful for this instruction.
  function automatic void ref_decode(input logic [31:0] i, input logic [31:0] a, b,
                                     output logic [17:0] c, output logic ak,
                                     output logic [3:0] op, output logic [31:0] res,
                                     output logic eq, output logic bt);
    logic [31:0] sx, zx, sh;
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'h0000, i[15:0]};
    sh = {27'd0, i[10:6]};
    c = '0; ak = 1'b0; op = 4'd0; res = 32'd0; eq = 1'b0; bt = 1'b0;
    case (i[31:26])
      6'h00: begin
        ak = 1'b1;
        c  = F_REGDST | F_REGWR | F_RS | F_RT;
        eq = (a == b);
        case (i[5:0])
          6'h20, 6'h21: begin op = 4'd5;  res = a + b; end
          6'h22, 6'h23: begin op = 4'd6;  res = a - b; end
          6'h24: begin op = 4'd7;  res = a & b; end
          6'h25: begin op = 4'd8;  res = a | b; end
          6'h26: begin op = 4'd9;  res = a ^ b; end
          6'h27: begin op = 4'd10; res = ~(a | b); end
          6'h2A: begin op = 4'd11; res = {31'd0, $signed(a) < $signed(b)}; end
          6'h2B: begin op = 4'd12; res = {31'd0, a < b}; end
          6'h00, 6'h02, 6'h03: begin
            c  = F_REGDST | F_REGWR | F_SHAMT | F_RT;
            eq = (b == sh);
            if (i[5:0] == 6'h00) begin op = 4'd0; res = b << sh[4:0]; end
            else if (i[5:0] == 6'h02) begin op = 4'd2; res = b >> sh[4:0]; end
            else begin op = 4'd1; res = $signed(b) >>> sh[4:0]; end
          end
          6'h08: begin ak = 1'b0; c = F_REGDST | F_JR | F_RS | F_RT; end
          6'h0C: begin ak = 1'b0; c = F_REGDST | F_SYS | F_RS | F_RT; end
          default: begin ak = 1'b0; c = '0; end
        endcase
      end
      6'h08, 6'h09: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS; op = 4'd5; res = a + sx; eq = (a == sx); end
      6'h0A: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS; op = 4'd11; res = {31'd0, $signed(a) < $signed(sx)}; eq = (a == sx); end
      6'h0B: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS; op = 4'd12; res = {31'd0, a < sx}; eq = (a == sx); end
      6'h0C: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS | F_ZEXT; op = 4'd7; res = a & zx; eq = (a == zx); end
      6'h0D: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS | F_ZEXT; op = 4'd8; res = a | zx; eq = (a == zx); end
      6'h0E: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS | F_ZEXT; op = 4'd9; res = a ^ zx; eq = (a == zx); end
      6'h23: begin ak = 1'b1; c = F_REGWR | F_ALUSRC | F_RS | F_MRD | F_M2R; op = 4'd5; res = a + sx; eq = (a == sx); end
      6'h2B: begin ak = 1'b1; c = F_ALUSRC | F_RS | F_RT | F_MWR; op = 4'd5; res = a + sx; eq = (a == sx); end
      6'h04: begin ak = 1'b1; c = F_BR | F_RS | F_RT; op = 4'd6; res = a - b; eq = (a == b); bt = eq; end
      6'h05: begin ak = 1'b1; c = F_BR | F_BNE | F_RS | F_RT; op = 4'd6; res = a - b; eq = (a == b); bt = !eq; end
      6'h02: c = F_JUMP;
      6'h03: c = F_JUMP | F_JAL | F_REGWR;
      6'h10: begin
        if (is_mfc0(i)) c = F_COP0;
        else if (is_mtc0(i)) c = F_COP0 | F_RT;
        else if (is_eret(i)) c = F_COP0 | F_ERET;
      end
      default: c = '0;
    endcase
  endfunction

  // Drive one instruction and compare every combinational output.
  task automatic apply(input logic [31:0] i, input logic [31:0] p, a, b,
                       input logic [2:0] s, input logic r);
    logic [17:0] ec;
    logic        ak, eeq, ebt;
    logic [3:0]  eop;
    logic [31:0] eres, edout;
    inst = i; pc = p; rs_data = a; rt_data = b; exp_src = s; reset = r;
    #1;
    ref_decode(i, a, b, ec, ak, eop, eres, eeq, ebt);
    m_has = m_ie && ((m_pend & ~m_mask) != 3'd0) && !is_eret(i) && !r;
    chk("ctrl", 32'(ctrl), 32'(ec));
    if (ak) begin
      chk("alu_op", 32'(alu_op), 32'(eop));
      chk("alu_result", alu_result, eres);
      chk("equal", 32'(equal), 32'(eeq));
    end
    chk("branch_taken", 32'(branch_taken), 32'(ebt));
    chk("has_exp", 32'(has_exp), 32'(m_has));
    chk("cp0_pcout", cp0_pcout, m_has ? 32'h0000_0800 : m_epc);
    chk("exp_block", 32'(exp_block), 32'(!m_ie));
    chk("ex_reg_write", 32'(ex_reg_write), 32'(is_mfc0(i)));
    if (is_mfc0(i)) begin
      case (i[15:11])
        5'd12:   edout = {28'd0, m_mask, m_ie};
        5'd13:   edout = {29'd0, m_pend};
        5'd14:   edout = m_epc;
        default: edout = 32'd0;
      endcase
      chk("cp0_dout", cp0_dout, edout);
    end
    $display("txn inst=%h pc=%h rs=%h rt=%h src=%b rst=%0d ctrl=%h res=%h has_exp=%0d pcout=%h",
             i, p, a, b, s, r, ctrl, alu_result, has_exp, cp0_pcout);
  endtask

  // Clock edge: advance the model by the rules of interrupt entry, eret,
  // mtc0 and edge-triggered pending bits.
  task automatic tick();
    logic [2:0] elig;
    logic       done;
    @(posedge clk);
    if (reset) begin
      m_ie = 1'b0; m_mask = 3'd0; m_pend = 3'd0; m_prev = 3'd0; m_epc = 32'd0;
    end else begin
      elig = m_pend & ~m_mask;
      if (m_has) begin
        m_epc = pc;
        m_ie  = 1'b0;
        done  = 1'b0;
        for (int j = 0; j < 3; j++) begin
          if (!done && elig[j]) begin
            m_pend[j] = 1'b0;
            done = 1'b1;
          end
        end
      end else begin
        if (is_eret(inst)) m_ie = 1'b1;
        if (is_mtc0(inst)) begin
          if (inst[15:11] == 5'd12) begin m_ie = rt_data[0]; m_mask = rt_data[3:1]; end
          else if (inst[15:11] == 5'd13) m_pend = rt_data[2:0];
          else if (inst[15:11] == 5'd14) m_epc = rt_data;
        end
      end
      m_pend = m_pend | (exp_src & ~m_prev);
      m_prev = exp_src;
    end
    @(negedge clk);
  endtask

  logic [5:0] r_fn [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                            6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h0C};
  logic [5:0] i_op [14] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                            6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};

  function automatic logic [31:0] rand_alu_inst();
    if ($urandom_range(0, 1) == 0)
      return r_inst(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    r_fn[$urandom_range(0, 14)]);
    return {i_op[$urandom_range(0, 13)], 26'($urandom)};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial begin
    logic [31:0] ins, a, b;
    logic [4:0]  rd;
    logic [2:0]  src;

    // raw reset edge before the model is meaningful
    inst = NOP; pc = 32'd0; rs_data = 32'd0; rt_data = 32'd0; exp_src = 3'd0; reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ie = 1'b0; m_mask = 3'd0; m_pend = 3'd0; m_prev = 3'd0; m_epc = 32'd0; m_has = 1'b0;

    // reset state
    apply(NOP, 32'd0, 32'd0, 32'd0, 3'd0, 1'b1);
    chk("rst_has_exp", 32'(has_exp), 32'd0);
    tick();
    apply(mfc0(5'd12), 32'd0, 32'd0, 32'd0, 3'd0, 1'b0); chk("rst_status", cp0_dout, 32'd0); tick();
    apply(mfc0(5'd13), 32'd0, 32'd0, 32'd0, 3'd0, 1'b0); chk("rst_cause", cp0_dout, 32'd0); tick();
    apply(mfc0(5'd14), 32'd0, 32'd0, 32'd0, 3'd0, 1'b0); chk("rst_epc", cp0_dout, 32'd0); tick();

    // addi with negative immediate
    apply(i_inst(6'h08, 5'd1, 5'd2, 16'hFFFF), 32'd4, 32'd5, 32'd0, 3'd0, 1'b0);
    chk("addi_res", alu_result, 32'd4);
    chk("addi_op", 32'(alu_op), 32'd5);
    chk("addi_regwrite", 32'(ctrl[16]), 32'd1);
    chk("addi_regdst", 32'(ctrl[17]), 32'd0);
    tick();
    // sra / sltu
    apply(r_inst(5'd0, 5'd3, 5'd4, 5'd4, 6'h03), 32'd8, 32'd0, 32'h8000_0000, 3'd0, 1'b0);
    chk("sra_res", alu_result, 32'hF800_0000);
    chk("sra_isshamt", 32'(ctrl[13]), 32'd1);
    tick();
    apply(r_inst(5'd1, 5'd2, 5'd3, 5'd0, 6'h2B), 32'd12, 32'd1, 32'hFFFF_FFFF, 3'd0, 1'b0);
    chk("sltu_res", alu_result, 32'd1);
    tick();
    // branches with equal operands
    apply(i_inst(6'h05, 5'd1, 5'd2, 16'h0010), 32'd16, 32'd7, 32'd7, 3'd0, 1'b0);
    chk("bne_equal", 32'(equal), 32'd1);
    chk("bne_taken", 32'(branch_taken), 32'd0);
    tick();
    apply(i_inst(6'h04, 5'd1, 5'd2, 16'h0010), 32'd20, 32'd7, 32'd7, 3'd0, 1'b0);
    chk("beq_taken", 32'(branch_taken), 32'd1);
    tick();

    // enable interrupts, raise source 1
    apply(mtc0(5'd12), 32'd24, 32'd0, 32'd1, 3'd0, 1'b0); tick();
    apply(NOP, 32'd28, 32'd0, 32'd0, 3'b010, 1'b0); chk("irq1_not_yet", 32'(has_exp), 32'd0); tick();
    apply(NOP, 32'h40, 32'd0, 32'd0, 3'b010, 1'b0);
    chk("irq1_taken", 32'(has_exp), 32'd1);
    chk("irq1_vec", cp0_pcout, 32'h0000_0800);
    tick();
    apply(mfc0(5'd14), 32'h800, 32'd0, 32'd0, 3'b010, 1'b0);
    chk("irq1_epc", cp0_dout, 32'h40);
    chk("mfc0_wr", 32'(ex_reg_write), 32'd1);
    tick();
    apply(mfc0(5'd13), 32'h804, 32'd0, 32'd0, 3'b010, 1'b0); chk("irq1_cleared", cp0_dout, 32'd0); tick();
    apply(mfc0(5'd12), 32'h808, 32'd0, 32'd0, 3'b010, 1'b0);
    chk("irq1_ie_off", cp0_dout, 32'd0);
    chk("irq1_block", 32'(exp_block), 32'd1);
    tick();
    apply(eret_i(), 32'h80C, 32'd0, 32'd0, 3'b010, 1'b0); chk("eret_pcout", cp0_pcout, 32'h40); tick();
    apply(mfc0(5'd12), 32'h40, 32'd0, 32'd0, 3'b010, 1'b0); chk("eret_ie_on", cp0_dout, 32'd1); tick();

    // simultaneous sources 0 and 2, mask 0
    apply(NOP, 32'h44, 32'd0, 32'd0, 3'b000, 1'b0); tick();
    apply(NOP, 32'h48, 32'd0, 32'd0, 3'b101, 1'b0); tick();
    apply(NOP, 32'h100, 32'd0, 32'd0, 3'b101, 1'b0); chk("dual_take0", 32'(has_exp), 32'd1); tick();
    apply(mfc0(5'd13), 32'h800, 32'd0, 32'd0, 3'b101, 1'b0); chk("dual_left2", cp0_dout, 32'd4); tick();
    apply(eret_i(), 32'h804, 32'd0, 32'd0, 3'b101, 1'b0);
    chk("dual_eret_noexp", 32'(has_exp), 32'd0);
    chk("dual_eret_pc", cp0_pcout, 32'h100);
    tick();
    apply(NOP, 32'h200, 32'd0, 32'd0, 3'b101, 1'b0); chk("dual_take2", 32'(has_exp), 32'd1); tick();
    apply(mfc0(5'd14), 32'h800, 32'd0, 32'd0, 3'b101, 1'b0); chk("dual_epc2", cp0_dout, 32'h200); tick();

    // interrupt entry drops a same-cycle mtc0 to EPC
    apply(mtc0(5'd12), 32'h804, 32'd0, 32'd1, 3'b000, 1'b0); tick();
    apply(NOP, 32'h808, 32'd0, 32'd0, 3'b010, 1'b0); tick();
    apply(mtc0(5'd14), 32'h300, 32'd0, 32'h0000_DEAD, 3'b010, 1'b0); chk("drop_mtc0_exp", 32'(has_exp), 32'd1); tick();
    apply(mfc0(5'd14), 32'h800, 32'd0, 32'd0, 3'b010, 1'b0); chk("drop_mtc0_epc", cp0_dout, 32'h300); tick();

    // reset in the middle of a pending interrupt
    apply(mtc0(5'd12), 32'h804, 32'd0, 32'd1, 3'b000, 1'b0); tick();
    apply(NOP, 32'h808, 32'd0, 32'd0, 3'b100, 1'b0); tick();
    apply(NOP, 32'h80C, 32'd0, 32'd0, 3'b000, 1'b1); chk("rst_mid_noexp", 32'(has_exp), 32'd0); tick();
    apply(mfc0(5'd12), 32'd0, 32'd0, 32'd0, 3'b000, 1'b0); chk("rst_mid_status", cp0_dout, 32'd0); tick();
    apply(mfc0(5'd13), 32'd4, 32'd0, 32'd0, 3'b000, 1'b0); chk("rst_mid_cause", cp0_dout, 32'd0); tick();
    apply(mfc0(5'd14), 32'd8, 32'd0, 32'd0, 3'b000, 1'b0); chk("rst_mid_epc", cp0_dout, 32'd0); tick();

    // random ALU/decode stream
    for (int n = 0; n < 120; n++) begin
      ins = rand_alu_inst();
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      apply(ins, 32'($urandom) & 32'hFFFF_FFFC, a, b, 3'd0, 1'b0);
      tick();
    end

    // random CP0 stream with interrupt traffic and occasional reset
    src = 3'd0;
    for (int n = 0; n < 400; n++) begin
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1:    ins = mtc0(rd);
        2, 3, 4: ins = mfc0(rd);
        5:       ins = eret_i();
        default: ins = rand_alu_inst();
      endcase
      if ($urandom_range(0, 2) == 0) src = 3'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      apply(ins, 32'($urandom) & 32'hFFFF_FFFC, a, b, src, ($urandom_range(0, 39) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
